// File: rtl/seg7_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decoder_if
//  Description : Digit request / segment pattern bundle for one display digit.
//                master : display controller (drives en, digit, dp, blank;
//                         observes seg)
//                slave  : seg7_decoder (consumes the request, drives seg)
//  Signals     : en    - capture enable, 1 = decoder register updates
//                digit - nibble to display, 0-15
//                dp    - decimal point request, active-high
//                blank - 1 = all segments and dp off
//                seg   - registered segment byte, {dp,g,f,e,d,c,b,a}
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg7_decoder_if;
  logic       en;
  logic [3:0] digit;
  logic       dp;
  logic       blank;
  logic [7:0] seg;

  modport master (
    output en,
    output digit,
    output dp,
    output blank,
    input  seg
  );

  modport slave (
    input  en,
    input  digit,
    input  dp,
    input  blank,
    output seg
  );
endinterface : seg7_decoder_if
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decoder
//  Description : Registered 4-bit nibble to seven-segment decoder, one per
//                display digit. Drives common-anode segments directly.
//  Parameters  : ACTIVE_LOW - 1 = lit segment is 0; 0 = whole byte inverted
//                HEX_MODE   - 1 = codes 10-15 show A,b,C,d,E,F;
//                             0 = codes 10-15 show a dash (segment g only)
//  Ports       : clk - system clock, rising edge
//                rst - synchronous active-high reset, forces all-off
//                bus - seg7_decoder_if.slave (en, digit, dp, blank -> seg)
//                      seg bit order: 0=a 1=b 2=c 3=d 4=e 5=f 6=g 7=dp
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder #(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit HEX_MODE   = 1'b1
) (
  input  wire logic      clk,
  input  wire logic      rst,
  seg7_decoder_if.slave  bus
);

  // All-off byte in the internal active-low domain; inverted on the way out
  // when the board wants active-high drive.
  localparam logic [7:0] c_all_off_al = 8'hFF;
  localparam logic [6:0] c_dash_al    = 7'h3F;   // only g lit

  localparam logic [7:0] c_all_off =
    ACTIVE_LOW ? c_all_off_al : ~c_all_off_al;

  logic [6:0] w_glyph_al;   // bits[6:0], active-low glyph for the nibble
  logic [7:0] w_byte_al;    // full byte incl. dp, active-low
  logic [7:0] w_seg_next;   // byte in output polarity
  logic [7:0] r_seg;

  // Glyph ROM, kept in active-low form so it reads like a datasheet.
  always_comb begin
    w_glyph_al = c_dash_al;
    case (bus.digit)
      4'h0: w_glyph_al = 7'h40;
      4'h1: w_glyph_al = 7'h79;
      4'h2: w_glyph_al = 7'h24;
      4'h3: w_glyph_al = 7'h30;
      4'h4: w_glyph_al = 7'h19;
      4'h5: w_glyph_al = 7'h12;
      4'h6: w_glyph_al = 7'h02;
      4'h7: w_glyph_al = 7'h78;   // a,b,c only
      4'h8: w_glyph_al = 7'h00;
      4'h9: w_glyph_al = 7'h10;
      4'hA: w_glyph_al = HEX_MODE ? 7'h08 : c_dash_al;
      4'hB: w_glyph_al = HEX_MODE ? 7'h03 : c_dash_al;
      4'hC: w_glyph_al = HEX_MODE ? 7'h46 : c_dash_al;
      4'hD: w_glyph_al = HEX_MODE ? 7'h21 : c_dash_al;
      4'hE: w_glyph_al = HEX_MODE ? 7'h06 : c_dash_al;
      4'hF: w_glyph_al = HEX_MODE ? 7'h0E : c_dash_al;
      default: w_glyph_al = c_dash_al;
    endcase
  end

  // Blank overrides the glyph and the decimal point together.
  always_comb begin
    w_byte_al = c_all_off_al;
    if (!bus.blank) begin
      w_byte_al = {~bus.dp, w_glyph_al};
    end
  end

  assign w_seg_next = ACTIVE_LOW ? w_byte_al : ~w_byte_al;

  // Single register stage: reset beats enable, enable-low holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= c_all_off;
    end else if (bus.en) begin
      r_seg <= w_seg_next;
    end
  end

  assign bus.seg = r_seg;

endmodule : seg7_decoder
`default_nettype wire

// File: tb/tb_seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_decoder
//  Description : Scoreboard bench for seg7_decoder. Three instances share one
//                stimulus stream: (ACTIVE_LOW,HEX_MODE) = (1,1), (1,0), (0,1).
//                Expected bytes are queued when inputs are driven and popped
//                after the following rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_decoder;

  logic clk;
  logic rst;

  int n_checks;
  int n_failures;

  // Reference bytes, ACTIVE_LOW=1, HEX_MODE=1, dp=0, for codes 0..15.
  logic [7:0] c_ref_full [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Per-instance configuration.
  bit c_al [3] = '{1'b1, 1'b1, 1'b0};
  bit c_hx [3] = '{1'b1, 1'b0, 1'b1};

  logic [7:0] r_model [3];       // model of each decoder's held byte
  logic [23:0] sb_q [$];         // {exp2, exp1, exp0}

  seg7_decoder_if bus0 ();
  seg7_decoder_if bus1 ();
  seg7_decoder_if bus2 ();

  seg7_decoder #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b1)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave));
  seg7_decoder #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave));
  seg7_decoder #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b1)) u_dut2 (
    .clk (clk), .rst (rst), .bus (bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs,
                           input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_failures++;
      $display("FAIL %s: seg=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Expected output byte for one instance given the applied inputs.
  function automatic logic [7:0] expect_byte(input int idx, input logic i_rst,
      input logic i_en, input logic [3:0] i_digit, input logic i_dp,
      input logic i_blank, input logic [7:0] held);
    logic [7:0] b;
    if (i_rst)       b = 8'hFF;
    else if (!i_en)  return held;
    else if (i_blank) b = 8'hFF;
    else begin
      b = c_ref_full[i_digit];
      if (!c_hx[idx] && i_digit >= 4'd10) b = 8'hBF;
      if (i_dp) b[7] = 1'b0;
    end
    return c_al[idx] ? b : ~b;
  endfunction

  // Drive one cycle of stimulus, queue expectations, then compare after edge.
  task automatic step(input string tag, input logic i_rst, input logic i_en,
                      input logic [3:0] i_digit, input logic i_dp,
                      input logic i_blank);
    logic [23:0] exp_all;
    rst = i_rst;
    bus0.en = i_en; bus0.digit = i_digit; bus0.dp = i_dp; bus0.blank = i_blank;
    bus1.en = i_en; bus1.digit = i_digit; bus1.dp = i_dp; bus1.blank = i_blank;
    bus2.en = i_en; bus2.digit = i_digit; bus2.dp = i_dp; bus2.blank = i_blank;
    for (int k = 0; k < 3; k++) begin
      r_model[k] = expect_byte(k, i_rst, i_en, i_digit, i_dp, i_blank,
                               r_model[k]);
    end
    sb_q.push_back({r_model[2], r_model[1], r_model[0]});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val({tag, "/queue_empty"}, 8'h00, 8'h01);
    end else begin
      exp_all = sb_q.pop_front();
      check_val({tag, "/al1_hx1"}, bus0.seg, exp_all[7:0]);
      check_val({tag, "/al1_hx0"}, bus1.seg, exp_all[15:8]);
      check_val({tag, "/al0_hx1"}, bus2.seg, exp_all[23:16]);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_failures = 0;
    for (int k = 0; k < 3; k++) r_model[k] = 8'h00;
    rst = 1'b1;
    bus0.en = 1'b0; bus0.digit = 4'd0; bus0.dp = 1'b0; bus0.blank = 1'b0;
    bus1.en = 1'b0; bus1.digit = 4'd0; bus1.dp = 1'b0; bus1.blank = 1'b0;
    bus2.en = 1'b0; bus2.digit = 4'd0; bus2.dp = 1'b0; bus2.blank = 1'b0;
    @(negedge clk);

    // Reset dominates en=1, then first decode of 8.
    step("rst0", 1'b1, 1'b1, 4'd8, 1'b0, 1'b0);
    step("rst1", 1'b1, 1'b1, 4'd8, 1'b0, 1'b0);
    step("rel8", 1'b0, 1'b1, 4'd8, 1'b0, 1'b0);

    // Full sweep of all 16 codes.
    for (int d = 0; d < 16; d++) begin
      step($sformatf("sweep%0d", d), 1'b0, 1'b1, 4'(d), 1'b0, 1'b0);
    end

    // Decimal point and blank.
    step("dp0",     1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    step("blankdp", 1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
    step("unblank", 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    step("dpF",     1'b0, 1'b1, 4'd15, 1'b1, 1'b0);

    // Enable hold.
    step("load3", 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
    step("hold5", 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
    step("hold9", 1'b0, 1'b0, 4'd9, 1'b1, 1'b1);
    step("load9", 1'b0, 1'b1, 4'd9, 1'b0, 1'b0);

    // Dash region and return to decimal.
    step("code12", 1'b0, 1'b1, 4'd12, 1'b0, 1'b0);
    step("code9",  1'b0, 1'b1, 4'd9,  1'b0, 1'b0);

    // Digit 1, mid-operation reset with en=0, resume, blank.
    step("d1",      1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    step("rst_en0", 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    step("idle_en0",1'b0, 1'b0, 4'd6, 1'b0, 1'b0);
    step("resume6", 1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
    step("blank",   1'b0, 1'b1, 4'd6, 1'b0, 1'b1);

    // A short run of random stimulus against the model.
    for (int i = 0; i < 40; i++) begin
      step($sformatf("rand%0d", i), ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    check_val("sb_drained", 8'(sb_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_seg7_decoder
`default_nettype wire

// File: doc/seg7_decoder.md
Name: seg7_decoder

Overview:
Registered 4-bit nibble to seven-segment pattern decoder, one instance per display digit. Four instances sit inside the score/time display block, one per 8-bit slice of the 32-bit segment bus. Output drives common-anode segments directly: segments and decimal point are active-low, and 1 means off.

Parameters:
ACTIVE_LOW, 1, 1 = segment lit when its bit is 0; 0 = whole 8-bit output inverted (lit = 1).
HEX_MODE, 1, 1 = codes 10-15 show A,b,C,d,E,F; 0 = codes 10-15 show a dash (segment g only).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  capture enable; 1 = register updates on this edge, 0 = hold.
digit  input  4  nibble to display, unsigned 0-15.
dp  input  1  decimal point request, active-high (1 = light dp).
blank  input  1  1 = all segments and dp off.
seg  output  8  registered segment pattern: bit0=a(top), bit1=b, bit2=c, bit3=d(bottom), bit4=e, bit5=f, bit6=g(middle), bit7=dp.

Behaviour:
- Single register stage; seg changes only on rising clk.
- Priority each edge: rst > en=0 > blank > decode.
- rst=1: seg <= all-off (8'hFF with ACTIVE_LOW=1, 8'h00 with ACTIVE_LOW=0), regardless of en.
- rst=0 and en=0: seg holds its value.
- en=1 and blank=1: seg <= all-off, dp included.
- en=1 and blank=0: seg <= pattern(digit) with bit7 = dp lit if dp=1, otherwise off.
- Latency: inputs sampled at edge N appear on seg right after edge N; no combinational input-to-output path.
- Active-low patterns in bits[6:0], ACTIVE_LOW=1:
  - Digits 0-9: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h.
  - HEX_MODE=1, codes 10-15: A=08h, b=03h, C=46h, d=21h, E=06h, F=0Eh.
  - HEX_MODE=0: codes 10-15 give 3Fh (dash).
- Full byte, ACTIVE_LOW=1, dp=0: 0=C0h, 1=F9h, 2=A4h, 3=B0h, 4=99h, 5=92h, 6=82h, 7=F8h, 8=80h, 9=90h, A=88h, b=83h, C=C6h, d=A1h, E=86h, F=8Eh. dp=1 clears bit7.
- ACTIVE_LOW=0: seg is the bitwise inverse of the active-low byte, for every case including reset and blank.
- Segment 7 pattern is a,b,c only (no f).
- Case coverage: all 16 digit codes are defined, so output is never X after reset.
- Reset mid-operation: the next edge forces all-off; decoding resumes on the first edge with rst=0 and en=1.

Test Plan:
- Reset: rst=1 for 2 cycles with digit=8, en=1 -> seg=FFh each cycle; release rst -> next edge seg=80h.
- Full sweep: ACTIVE_LOW=1, HEX_MODE=1, en=1, dp=0, digit 0..15 one per cycle -> seg matches C0h,F9h,A4h,B0h,99h,92h,82h,F8h,80h,90h,88h,83h,C6h,A1h,86h,8Eh, each one cycle after its input.
- Decimal point and blank: digit=0, dp=1 -> 40h; then blank=1 with dp=1 -> FFh; then blank=0 -> 40h.
- Enable hold: digit=3 with en=1 -> B0h; en=0 and digit stepped through 5,9 -> seg stays B0h; en=1 -> seg becomes 90h.
- HEX_MODE=0: digit=12 -> BFh; digit=9 -> 90h.
- ACTIVE_LOW=0: digit=1 -> 06h; reset -> 00h; blank -> 00h.
